// File: rtl/crash_avoid_ctrl_if.sv
// ---------------------------------------------------------------------------
// crash_avoid_ctrl_if
// Drive-command handshake between a command source (master) and the
// crash-avoidance controller (slave).
//   cmd_valid : a drive command is offered
//   cmd_ready : the controller can take a command this cycle
//   cmd_dir   : 00 stop, 01 forward, 10 reverse, 11 spin right
//   cmd_speed : requested 8-bit PWM duty
// A command transfers on a cycle where cmd_valid and cmd_ready are both high.
// ---------------------------------------------------------------------------
interface crash_avoid_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dir;
    logic [7:0] cmd_speed;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_speed,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_speed,
        output cmd_ready
    );
endinterface

// File: rtl/crash_avoid_ctrl.sv
// ---------------------------------------------------------------------------
// crash_avoid_ctrl
// Differential-drive motor controller with an automatic obstacle escape.
// Accepts drive commands over a valid/ready handshake and turns them into
// per-wheel PWM and direction.  An obstacle seen while moving forward or
// spinning runs a fixed escape: BRAKE -> REVERSE -> TURN -> HOLDOFF -> IDLE.
//
// Ports
//   clk          : single clock, everything on the rising edge
//   rst_n        : synchronous active-low reset
//   isCrash      : proximity-sensor obstacle flag, asynchronous to clk
//   cmd          : command handshake (crash_avoid_ctrl_if.slave)
//   pwm_left/right : motor PWM outputs
//   dir_left/right : motor direction, 1 = forward, 0 = reverse
//   state        : current FSM state code (IDLE 0 .. HOLDOFF 5)
//   crash_event  : one-cycle pulse on each entry to BRAKE
//   crash_count  : saturating count of BRAKE entries
//
// Build option
//   CRASH_DEBOUNCE_EN : when defined, a crash only triggers after the
//                       synchronized flag has been high 16 cycles in a row.
// ---------------------------------------------------------------------------
module crash_avoid_ctrl #(
    parameter int PWM_DIV        = 450,
    parameter int BRAKE_CYCLES   = 4500,
    parameter int REVERSE_CYCLES = 45000,
    parameter int TURN_CYCLES    = 45000,
    parameter int HOLDOFF_CYCLES = 4500,
    parameter int ESCAPE_DUTY    = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                isCrash,
    crash_avoid_ctrl_if.slave   cmd,
    output logic                pwm_left,
    output logic                pwm_right,
    output logic                dir_left,
    output logic                dir_right,
    output logic [2:0]          state,
    output logic                crash_event,
    output logic [7:0]          crash_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_BRAKE   = 3'd2,
        ST_REVERSE = 3'd3,
        ST_TURN    = 3'd4,
        ST_HOLDOFF = 3'd5
    } state_t;

    localparam int MAX_BR  = (BRAKE_CYCLES > REVERSE_CYCLES) ? BRAKE_CYCLES : REVERSE_CYCLES;
    localparam int MAX_TH  = (TURN_CYCLES > HOLDOFF_CYCLES) ? TURN_CYCLES : HOLDOFF_CYCLES;
    localparam int MAX_DW  = (MAX_BR > MAX_TH) ? MAX_BR : MAX_TH;
    localparam int DW      = $clog2(MAX_DW + 1);
    localparam int PRE_W   = $clog2(PWM_DIV + 1);

    localparam logic [1:0] DIR_STOP    = 2'b00;
    localparam logic [1:0] DIR_REVERSE = 2'b10;
    localparam logic [1:0] DIR_SPIN    = 2'b11;

    logic             crash_meta;
    logic             crash_s;
    logic             crash_trig;
    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       pwm_cnt;
    state_t           state_q;
    state_t           state_d;
    logic [DW-1:0]    dwell_q;
    logic [DW-1:0]    dwell_d;
    logic [1:0]       dir_q;
    logic [1:0]       dir_d;
    logic [7:0]       speed_q;
    logic [7:0]       speed_d;
    logic [7:0]       duty;
    logic             drv_left;
    logic             drv_right;
    logic             accept;
    logic             brake_entry;

    assign accept      = cmd.cmd_valid && cmd.cmd_ready;
    assign brake_entry = (state_d == ST_BRAKE) && (state_q != ST_BRAKE);
    assign state       = state_q;

    // Two-flop synchronizer for the asynchronous obstacle flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crash_meta <= 1'b0;
            crash_s    <= 1'b0;
        end else begin
            crash_meta <= isCrash;
            crash_s    <= crash_meta;
        end
    end

`ifdef CRASH_DEBOUNCE_EN
    // Counts previous consecutive high cycles of crash_s, saturating at 15,
    // so the trigger fires on the 16th consecutive high cycle.
    logic [3:0] deb_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_cnt <= 4'd0;
        end else if (!crash_s) begin
            deb_cnt <= 4'd0;
        end else if (deb_cnt != 4'd15) begin
            deb_cnt <= deb_cnt + 4'd1;
        end
    end

    assign crash_trig = crash_s && (deb_cnt == 4'd15);
`else
    assign crash_trig = crash_s;
`endif

    // Free-running PWM timebase; never touched by the FSM so the PWM phase
    // is continuous across state changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            pwm_cnt <= 8'd0;
        end else if (pre_cnt == PRE_W'(PWM_DIV - 1)) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // FSM state, dwell counter and latched command registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dwell_q <= '0;
            dir_q   <= DIR_STOP;
            speed_q <= 8'd0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
        end
    end

    // Next-state and per-state motor drive.  In HOLDOFF the dwell counter
    // counts consecutive clear cycles; any high crash_s restarts it.
    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q + DW'(1);
        dir_d     = dir_q;
        speed_d   = speed_q;
        duty      = 8'd0;
        drv_left  = 1'b1;
        drv_right = 1'b1;

        case (state_q)
            ST_IDLE: begin
                dwell_d = '0;
                if (accept) begin
                    dir_d   = cmd.cmd_dir;
                    speed_d = cmd.cmd_speed;
                    if ((cmd.cmd_dir != DIR_STOP) && (cmd.cmd_speed != 8'd0)) begin
                        state_d = ST_DRIVE;
                    end
                end
            end

            ST_DRIVE: begin
                dwell_d = '0;
                duty    = speed_q;
                if (dir_q == DIR_REVERSE) begin
                    drv_left  = 1'b0;
                    drv_right = 1'b0;
                end else if (dir_q == DIR_SPIN) begin
                    drv_right = 1'b0;
                end
                // A crash beats a command offered on the same cycle.
                if (crash_trig && (dir_q != DIR_REVERSE)) begin
                    state_d = ST_BRAKE;
                end else if (accept) begin
                    dir_d   = cmd.cmd_dir;
                    speed_d = cmd.cmd_speed;
                    if ((cmd.cmd_dir != DIR_STOP) && (cmd.cmd_speed != 8'd0)) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_BRAKE: begin
                if (dwell_q == DW'(BRAKE_CYCLES - 1)) begin
                    state_d = ST_REVERSE;
                end
            end

            ST_REVERSE: begin
                duty      = 8'(ESCAPE_DUTY);
                drv_left  = 1'b0;
                drv_right = 1'b0;
                if (dwell_q == DW'(REVERSE_CYCLES - 1)) begin
                    state_d = ST_TURN;
                end
            end

            ST_TURN: begin
                duty      = 8'(ESCAPE_DUTY);
                drv_right = 1'b0;
                if (dwell_q == DW'(TURN_CYCLES - 1)) begin
                    state_d = ST_HOLDOFF;
                end
            end

            ST_HOLDOFF: begin
                if (crash_s) begin
                    dwell_d = '0;
                end
                if (crash_trig) begin
                    state_d = ST_REVERSE;
                end else if (!crash_s && (dwell_q == DW'(HOLDOFF_CYCLES - 1))) begin
                    state_d = ST_IDLE;
                    dir_d   = DIR_STOP;
                    speed_d = 8'd0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                dwell_d = '0;
            end
        endcase

        if (state_d != state_q) begin
            dwell_d = '0;
        end
    end

    // Registered outputs so that reset forces them to known values and
    // cmd_ready only comes up on the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_left      <= 1'b0;
            pwm_right     <= 1'b0;
            dir_left      <= 1'b1;
            dir_right     <= 1'b1;
            cmd.cmd_ready <= 1'b0;
            crash_event   <= 1'b0;
            crash_count   <= 8'd0;
        end else begin
            pwm_left      <= (pwm_cnt < duty);
            pwm_right     <= (pwm_cnt < duty);
            dir_left      <= drv_left;
            dir_right     <= drv_right;
            cmd.cmd_ready <= (state_d == ST_IDLE) || (state_d == ST_DRIVE);
            crash_event   <= brake_entry;
            if (brake_entry && (crash_count != 8'hFF)) begin
                crash_count <= crash_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/crash_avoid_ctrl.md
CRASH_AVOID_CTRL -- requirements
Module: crash_avoid_ctrl

Interface
REQ-001 SHALL have parameter PWM_DIV, default 450: clk cycles per PWM counter step.
REQ-002 SHALL have parameter BRAKE_CYCLES, default 4500: clk cycles spent in BRAKE.
REQ-003 SHALL have parameter REVERSE_CYCLES, default 45000: clk cycles spent in REVERSE.
REQ-004 SHALL have parameter TURN_CYCLES, default 45000: clk cycles spent in TURN.
REQ-005 SHALL have parameter HOLDOFF_CYCLES, default 4500: consecutive clear cycles required before returning to IDLE.
REQ-006 SHALL have parameter ESCAPE_DUTY, default 128: 8-bit duty used in REVERSE and TURN.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port isCrash, input, 1 bit: obstacle flag from the proximity sensor, asynchronous to clk.
REQ-010 SHALL have port cmd_valid, input, 1 bit: a drive command is offered.
REQ-011 SHALL have port cmd_ready, output, 1 bit: a command is accepted on this cycle when both cmd_valid and cmd_ready are high.
REQ-012 SHALL have port cmd_dir, input, 2 bits: 00 stop, 01 forward, 10 reverse, 11 spin right.
REQ-013 SHALL have port cmd_speed, input, 8 bits: requested duty.
REQ-014 SHALL have ports pwm_left and pwm_right, outputs, 1 bit each: motor PWM.
REQ-015 SHALL have ports dir_left and dir_right, outputs, 1 bit each: 1 = forward, 0 = reverse.
REQ-016 SHALL have port state, output, 3 bits: current FSM state code.
REQ-017 SHALL have port crash_event, output, 1 bit: one-cycle pulse on entry to BRAKE.
REQ-018 SHALL have port crash_count, output, 8 bits: saturating count of BRAKE entries.

Function
REQ-019 isCrash SHALL pass through a 2-flop synchronizer; the synchronized value is crash_s, 2 cycles of latency.
REQ-020 PWM SHALL use an 8-bit counter that advances once every PWM_DIV clk cycles and wraps from 255 to 0.
REQ-021 A PWM output SHALL be high while counter < duty; duty 0 gives constant low and duty 255 gives 255/256 high.
REQ-022 FSM states and codes SHALL be: IDLE = 0, DRIVE = 1, BRAKE = 2, REVERSE = 3, TURN = 4, HOLDOFF = 5; unused codes return to IDLE on the next cycle.
REQ-023 cmd_ready SHALL be high only in IDLE and DRIVE.
REQ-024 An accepted command SHALL latch cmd_dir and cmd_speed on the cycle of acceptance.
REQ-025 The FSM SHALL go to DRIVE on the next cycle for a nonzero dir with speed > 0; otherwise it SHALL go to IDLE.
REQ-026 In DRIVE, outputs SHALL follow the latched command:
- forward: both motors forward
- reverse: both motors reverse
- spin: left forward, right reverse
- duty: latched speed
REQ-027 In IDLE, both duties SHALL be 0 and both dir outputs SHALL be 1.
REQ-028 From DRIVE with the forward or spin command latched, crash_s = 1 SHALL move the FSM to BRAKE on the next cycle, pulse crash_event and increment crash_count (saturating at 255).
REQ-029 In DRIVE with the reverse command, crash_s SHALL be ignored.
REQ-030 If cmd accept and crash_s occur on the same cycle, the crash SHALL win: the command is discarded and the FSM enters BRAKE.
REQ-031 BRAKE SHALL hold duty 0 for BRAKE_CYCLES cycles, then go to REVERSE.
REQ-032 REVERSE SHALL drive both motors in reverse at ESCAPE_DUTY for REVERSE_CYCLES cycles, then go to TURN.
REQ-033 TURN SHALL use left forward, right reverse at ESCAPE_DUTY for TURN_CYCLES cycles, then go to HOLDOFF.
REQ-034 crash_s SHALL NOT restart BRAKE, REVERSE or TURN.
REQ-035 HOLDOFF SHALL hold duty 0 and count consecutive crash_s = 0 cycles.
REQ-036 In HOLDOFF, crash_s = 1 SHALL clear the count and move the FSM to REVERSE; this re-entry SHALL NOT pulse crash_event or increment crash_count.
REQ-037 When the HOLDOFF count reaches HOLDOFF_CYCLES, the FSM SHALL go to IDLE and the latched command SHALL be cleared.
REQ-038 Each state dwell counter SHALL be cleared on every state change.
REQ-039 The PWM counter SHALL run continuously and SHALL NOT be reset on state change.

Reset
REQ-040 While rst_n = 0 at a clk edge, the block SHALL set:
- state = IDLE
- PWM counter, prescaler and dwell counters = 0
- crash_count = 0, crash_event = 0
- synchronizer flops = 0
- latched command = stop, speed 0
- pwm_left = pwm_right = 0, dir_left = dir_right = 1
- cmd_ready = 0
REQ-041 cmd_ready SHALL rise on the first cycle after rst_n is released.
REQ-042 Reset asserted mid-escape SHALL abandon the escape immediately, with no completion of BRAKE, REVERSE or TURN.

Configuration
REQ-043 With macro CRASH_DEBOUNCE_EN defined, a DRIVE to BRAKE transition SHALL require crash_s high for 16 consecutive cycles.
REQ-044 With CRASH_DEBOUNCE_EN defined, any low crash_s SHALL reset the debounce count; HOLDOFF re-entry SHALL use the same debounce.
REQ-045 Without CRASH_DEBOUNCE_EN, the transition SHALL occur on the first cycle crash_s = 1 and no debounce logic SHALL be present.

Verification
REQ-046 SHALL cover PWM duty, with PWM_DIV = 1, cmd forward speed 64: pwm_left high exactly 64 of every 256 cycles, dir_left = dir_right = 1.
REQ-047 SHALL cover a full escape sequence, with BRAKE/REVERSE/TURN/HOLDOFF = 4/8/8/4 and isCrash pulsed in forward DRIVE:
- state 1 -> 2 exactly 3 cycles after isCrash rises
- crash_event is a single one-cycle pulse
- state then shows 2 (4 cycles), 3 (8 cycles), 4 (8 cycles), 5 (4 cycles), then 0
- crash_count = 1 at the end
REQ-048 SHALL cover crash ignored in reverse: cmd reverse speed 100 with isCrash held high leaves state = 1 and crash_count = 0.
REQ-049 SHALL cover a crash during HOLDOFF: isCrash reasserted at HOLDOFF cycle 2 gives state 5 -> 3 and crash_count unchanged.
REQ-050 SHALL cover saturation and reset: 300 crash events leave crash_count = 255; rst_n low mid-REVERSE gives state = 0 and all outputs at their reset values on the next edge.
REQ-051 SHALL cover debounce, with CRASH_DEBOUNCE_EN defined: a 10-cycle isCrash pulse causes no BRAKE, and a 20-cycle pulse causes BRAKE.
